ds_operand_stage: RTL and testbench

//  Parametrised decode-stage pipeline register with operand read, N-source forwarding and interlock.

---
 rtl/ds_operand_stage.sv | 119 +++++++++++
 tb/tb_ds_operand_stage.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ds_operand_stage.sv
// Decode-stage pipeline register: latches PC/payload/sources, resolves operands through an
// N-producer bypass network and interlocks while the winning producer's result is not ready.
module ds_operand_stage #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned RADDR_W   = 5,
   parameter int unsigned NUM_SRC   = 2,
   parameter int unsigned NUM_FWD   = 3,
   parameter int unsigned PAYLOAD_W = 64,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       fs2ds_valid,
   output logic                       ds_allowin,
   input  logic [31:0]                fs_pc,
   input  logic [PAYLOAD_W-1:0]       fs_payload,
   input  logic [NUM_SRC*RADDR_W-1:0] fs_src_addr,
   input  logic [NUM_SRC-1:0]         fs_src_used,
   input  logic                       flush,
   output logic                       ds2es_valid,
   input  logic                       es_allowin,
   output logic                       ds_valid,
   output logic [31:0]                ds_pc,
   output logic [PAYLOAD_W-1:0]       ds_payload,
   output logic [NUM_SRC*RADDR_W-1:0] rf_raddr,
   input  logic [NUM_SRC*XLEN-1:0]    rf_rdata,
   input  logic [NUM_FWD-1:0]         fwd_valid,
   input  logic [NUM_FWD-1:0]         fwd_we,
   input  logic [NUM_FWD-1:0]         fwd_ready,
   input  logic [NUM_FWD*RADDR_W-1:0] fwd_dest,
   input  logic [NUM_FWD*XLEN-1:0]    fwd_data,
   output logic [NUM_SRC*XLEN-1:0]    ds_src_data,
   output logic                       ds_stall,
   input  logic                       stat_clr,
   output logic [CNT_W-1:0]           stall_cycles
);

   logic                       valid_q, valid_d;
   logic [31:0]                pc_q;
   logic [PAYLOAD_W-1:0]       payload_q;
   logic [NUM_SRC*RADDR_W-1:0] src_addr_q;
   logic [NUM_SRC-1:0]         src_used_q;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [NUM_SRC-1:0]         hz;
   logic                       ready_go;
   logic                       capture;

   // Producers are scanned oldest-first so the youngest match overwrites and wins.
   always_comb begin
      hz          = '0;
      ds_src_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (src_addr_q[i*RADDR_W +: RADDR_W] != '0) begin
            ds_src_data[i*XLEN +: XLEN] = rf_rdata[i*XLEN +: XLEN];
         end
         for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_valid[k] && fwd_we[k] && src_used_q[i] &&
                (src_addr_q[i*RADDR_W +: RADDR_W] != '0) &&
                (fwd_dest[k*RADDR_W +: RADDR_W] == src_addr_q[i*RADDR_W +: RADDR_W])) begin
               ds_src_data[i*XLEN +: XLEN] = fwd_data[k*XLEN +: XLEN];
               hz[i]                       = ~fwd_ready[k];
            end
         end
      end
   end

   always_comb begin
      ds_stall    = valid_q & (|hz);
      ready_go    = ~ds_stall;
      ds_allowin  = ~valid_q | (ready_go & es_allowin);
      ds2es_valid = valid_q & ready_go & ~flush;
      capture     = fs2ds_valid & ds_allowin & ~flush;
   end

   always_comb begin
      valid_d = valid_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (ds_allowin) begin
         valid_d = fs2ds_valid;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stat_clr) begin
         cnt_d = '0;
      end else if (ds_stall && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         payload_q  <= '0;
         src_addr_q <= '0;
         src_used_q <= '0;
         cnt_q      <= '0;
      end else begin
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         if (capture) begin
            pc_q       <= fs_pc;
            payload_q  <= fs_payload;
            src_addr_q <= fs_src_addr;
            src_used_q <= fs_src_used;
         end
      end
   end

   assign ds_valid     = valid_q;
   assign ds_pc        = pc_q;
   assign ds_payload   = payload_q;
   assign rf_raddr     = src_addr_q;
   assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_ds_operand_stage.sv
// Self-checking bench for ds_operand_stage: directed scenarios plus randomized traffic checked
// against a rule-level reference model.
module tb_ds_operand_stage;

   localparam int XLEN = 32;
   localparam int RW   = 5;
   localparam int NS   = 2;
   localparam int NF   = 3;
   localparam int PW   = 64;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic             clk = 1'b0;
   logic             resetn;
   logic             fs2ds_valid;
   logic             ds_allowin;
   logic [31:0]      fs_pc;
   logic [PW-1:0]    fs_payload;
   logic [NS*RW-1:0] fs_src_addr;
   logic [NS-1:0]    fs_src_used;
   logic             flush;
   logic             ds2es_valid;
   logic             es_allowin;
   logic             ds_valid;
   logic [31:0]      ds_pc;
   logic [PW-1:0]    ds_payload;
   logic [NS*RW-1:0] rf_raddr;
   logic [NS*XLEN-1:0] rf_rdata;
   logic [NF-1:0]    fwd_valid;
   logic [NF-1:0]    fwd_we;
   logic [NF-1:0]    fwd_ready;
   logic [NF*RW-1:0] fwd_dest;
   logic [NF*XLEN-1:0] fwd_data;
   logic [NS*XLEN-1:0] ds_src_data;
   logic             ds_stall;
   logic             stat_clr;
   logic [CW-1:0]    stall_cycles;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic             m_valid;
   logic [31:0]      m_pc;
   logic [PW-1:0]    m_payload;
   logic [NS*RW-1:0] m_addr;
   logic [NS-1:0]    m_used;
   int               m_cnt;
   logic [NS*XLEN-1:0] exp_data;
   logic [NS-1:0]    exp_hz;
   logic             exp_stall, exp_allowin, exp_out;

   always #5 clk = ~clk;

   ds_operand_stage #(
      .XLEN(XLEN), .RADDR_W(RW), .NUM_SRC(NS), .NUM_FWD(NF), .PAYLOAD_W(PW), .CNT_W(CW)
   ) dut (
      .clk(clk), .resetn(resetn), .fs2ds_valid(fs2ds_valid), .ds_allowin(ds_allowin),
      .fs_pc(fs_pc), .fs_payload(fs_payload), .fs_src_addr(fs_src_addr),
      .fs_src_used(fs_src_used), .flush(flush), .ds2es_valid(ds2es_valid),
      .es_allowin(es_allowin), .ds_valid(ds_valid), .ds_pc(ds_pc), .ds_payload(ds_payload),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .fwd_valid(fwd_valid), .fwd_we(fwd_we),
      .fwd_ready(fwd_ready), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
      .ds_src_data(ds_src_data), .ds_stall(ds_stall), .stat_clr(stat_clr),
      .stall_cycles(stall_cycles)
   );

   // First (youngest) matching producer decides each operand; register 0 reads as zero.
   task automatic model_eval();
      int a;
      exp_hz = '0;
      for (int i = 0; i < NS; i++) begin
         a = int'(m_addr[i*RW +: RW]);
         exp_data[i*XLEN +: XLEN] = (a == 0) ? 32'd0 : rf_rdata[i*XLEN +: XLEN];
         for (int k = 0; k < NF; k++) begin
            if (fwd_valid[k] && fwd_we[k] && m_used[i] && a != 0 &&
                int'(fwd_dest[k*RW +: RW]) == a) begin
               exp_data[i*XLEN +: XLEN] = fwd_data[k*XLEN +: XLEN];
               exp_hz[i] = !fwd_ready[k];
               break;
            end
         end
      end
      exp_stall   = m_valid && (exp_hz != 0);
      exp_allowin = !m_valid || (!exp_stall && es_allowin);
      exp_out     = m_valid && !exp_stall && !flush;
   endtask

   task automatic model_advance();
      if (stat_clr) m_cnt = 0;
      else if (exp_stall && m_cnt < CMAX) m_cnt = m_cnt + 1;
      if (fs2ds_valid && exp_allowin && !flush) begin
         m_pc = fs_pc; m_payload = fs_payload; m_addr = fs_src_addr; m_used = fs_src_used;
      end
      if (flush) m_valid = 1'b0;
      else if (exp_allowin) m_valid = fs2ds_valid;
   endtask

   task automatic settle();
      #2;
      model_eval();
   endtask

   task automatic tick();
      model_eval();
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      fs2ds_valid = 0; fs_pc = '0; fs_payload = '0; fs_src_addr = '0; fs_src_used = '0;
      flush = 0; es_allowin = 1; rf_rdata = '0; fwd_valid = '0; fwd_we = '0; fwd_ready = '0;
      fwd_dest = '0; fwd_data = '0; stat_clr = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      resetn = 0;
      m_valid = 0; m_pc = '0; m_payload = '0; m_addr = '0; m_used = '0; m_cnt = 0;
      #2;
      resetn = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic capture(input logic [31:0] pc, input logic [NS*RW-1:0] addr,
                          input logic [NS-1:0] used);
      fs2ds_valid = 1; fs_pc = pc; fs_payload = {pc, ~pc}; fs_src_addr = addr;
      fs_src_used = used;
      tick();
      fs2ds_valid = 0;
   endtask

   task automatic test_reset();
      do_reset();
      settle();
      checks += 8;
      if (ds_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h want 0", ds_valid); end
      if (ds_pc !== 32'd0) begin errors++; $display("FAIL rst_pc got %0h want 0", ds_pc); end
      if (ds_payload !== '0) begin errors++; $display("FAIL rst_payload got %0h want 0", ds_payload); end
      if (rf_raddr !== '0) begin errors++; $display("FAIL rst_raddr got %0h want 0", rf_raddr); end
      if (stall_cycles !== '0) begin errors++; $display("FAIL rst_cnt got %0d want 0", stall_cycles); end
      if (ds_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0h want 0", ds_stall); end
      if (ds2es_valid !== 1'b0) begin errors++; $display("FAIL rst_out got %0h want 0", ds2es_valid); end
      if (ds_allowin !== 1'b1) begin errors++; $display("FAIL rst_allowin got %0h want 1", ds_allowin); end
   endtask

   task automatic test_rf_read();
      do_reset();
      rf_rdata = {32'h0, 32'h1234};
      capture(32'h1c000000, {5'd0, 5'd5}, 2'b01);
      settle();
      checks += 4;
      if (ds_valid !== 1'b1) begin errors++; $display("FAIL rf_valid got %0h want 1", ds_valid); end
      if (ds_pc !== 32'h1c000000) begin errors++; $display("FAIL rf_pc got %0h want 1c000000", ds_pc); end
      if (ds_src_data[31:0] !== 32'h1234) begin
         errors++; $display("FAIL rf_data0 got %0h want 1234", ds_src_data[31:0]);
      end
      if (ds2es_valid !== 1'b1) begin errors++; $display("FAIL rf_out got %0h want 1", ds2es_valid); end
   endtask

   task automatic test_priority();
      do_reset();
      capture(32'h100, {5'd0, 5'd7}, 2'b01);
      fwd_valid = 3'b101; fwd_we = 3'b101; fwd_ready = 3'b101;
      fwd_dest = {5'd7, 5'd0, 5'd7}; fwd_data = {32'hCC, 32'h0, 32'hAA};
      settle();
      checks += 2;
      if (ds_src_data[31:0] !== 32'hAA) begin
         errors++; $display("FAIL prio_data0 got %0h want aa", ds_src_data[31:0]);
      end
      if (ds_stall !== 1'b0) begin errors++; $display("FAIL prio_stall got %0h want 0", ds_stall); end
   endtask

   task automatic test_interlock();
      do_reset();
      capture(32'h200, {5'd4, 5'd0}, 2'b10);
      // Young unready load and an older ready writer of the same register
      fwd_valid = 3'b011; fwd_we = 3'b011; fwd_ready = 3'b010;
      fwd_dest = {5'd0, 5'd4, 5'd4}; fwd_data = {32'h0, 32'h77, 32'h0};
      settle();
      checks += 3;
      if (ds_stall !== 1'b1) begin errors++; $display("FAIL il_stall got %0h want 1", ds_stall); end
      if (ds2es_valid !== 1'b0) begin errors++; $display("FAIL il_out got %0h want 0", ds2es_valid); end
      if (ds_allowin !== 1'b0) begin errors++; $display("FAIL il_allowin got %0h want 0", ds_allowin); end
      tick();
      fwd_valid = 3'b010; fwd_we = 3'b010; fwd_ready = 3'b010; fwd_data = {32'h0, 32'h55, 32'h0};
      settle();
      checks += 4;
      if (ds_stall !== 1'b0) begin errors++; $display("FAIL il_stall2 got %0h want 0", ds_stall); end
      if (stall_cycles !== 4'd1) begin errors++; $display("FAIL il_cnt got %0d want 1", stall_cycles); end
      if (ds_src_data[63:32] !== 32'h55) begin
         errors++; $display("FAIL il_data1 got %0h want 55", ds_src_data[63:32]);
      end
      if (ds2es_valid !== 1'b1) begin errors++; $display("FAIL il_out2 got %0h want 1", ds2es_valid); end
   endtask

   task automatic test_zero_unused();
      do_reset();
      rf_rdata = {32'h0, 32'hDEAD};
      capture(32'h300, {5'd0, 5'd0}, 2'b01);
      fwd_valid = 3'b001; fwd_we = 3'b001; fwd_ready = 3'b000; fwd_dest = '0;
      fwd_data = {32'h0, 32'h0, 32'h99};
      settle();
      checks += 2;
      if (ds_stall !== 1'b0) begin errors++; $display("FAIL r0_stall got %0h want 0", ds_stall); end
      if (ds_src_data[31:0] !== 32'h0) begin
         errors++; $display("FAIL r0_data got %0h want 0", ds_src_data[31:0]);
      end
      tick();
      capture(32'h304, {5'd9, 5'd9}, 2'b00);
      fwd_dest = {5'd0, 5'd0, 5'd9};
      settle();
      checks += 1;
      if (ds_stall !== 1'b0) begin errors++; $display("FAIL unused_stall got %0h want 0", ds_stall); end
   endtask

   task automatic test_flush_stall();
      do_reset();
      capture(32'h400, {5'd0, 5'd3}, 2'b01);
      fwd_valid = 3'b001; fwd_we = 3'b001; fwd_ready = 3'b000; fwd_dest = {5'd0, 5'd0, 5'd3};
      settle();
      checks += 1;
      if (ds_stall !== 1'b1) begin errors++; $display("FAIL fl_stall got %0h want 1", ds_stall); end
      tick();
      flush = 1; fs2ds_valid = 1; fs_pc = 32'h500; fs_src_addr = {5'd1, 5'd1};
      settle();
      checks += 1;
      if (ds2es_valid !== 1'b0) begin errors++; $display("FAIL fl_out got %0h want 0", ds2es_valid); end
      tick();
      flush = 0; fs2ds_valid = 0;
      settle();
      checks += 3;
      if (ds_valid !== 1'b0) begin errors++; $display("FAIL fl_valid got %0h want 0", ds_valid); end
      if (ds_pc !== 32'h400) begin errors++; $display("FAIL fl_pc got %0h want 400", ds_pc); end
      if (stall_cycles !== 4'd2) begin errors++; $display("FAIL fl_cnt got %0d want 2", stall_cycles); end
   endtask

   task automatic test_saturate();
      do_reset();
      capture(32'h600, {5'd0, 5'd6}, 2'b01);
      fwd_valid = 3'b100; fwd_we = 3'b100; fwd_ready = 3'b000; fwd_dest = {5'd6, 5'd0, 5'd0};
      for (int n = 0; n < 15; n++) tick();
      settle();
      checks += 1;
      if (stall_cycles !== 4'd15) begin errors++; $display("FAIL sat_15 got %0d want 15", stall_cycles); end
      for (int n = 0; n < 5; n++) tick();
      settle();
      checks += 2;
      if (stall_cycles !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", stall_cycles); end
      if (ds_stall !== 1'b1) begin errors++; $display("FAIL sat_stall got %0h want 1", ds_stall); end
      stat_clr = 1;
      tick();
      stat_clr = 0;
      settle();
      checks += 1;
      if (stall_cycles !== 4'd0) begin errors++; $display("FAIL sat_clr got %0d want 0", stall_cycles); end
      // Asynchronous reset in the middle of a stall
      #1;
      resetn = 0;
      #1;
      checks += 3;
      if (ds_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %0h want 0", ds_valid); end
      if (ds_stall !== 1'b0) begin errors++; $display("FAIL arst_stall got %0h want 0", ds_stall); end
      if (ds2es_valid !== 1'b0) begin errors++; $display("FAIL arst_out got %0h want 0", ds2es_valid); end
      resetn = 1;
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 600; n++) begin
         fs2ds_valid = 1'($urandom);
         fs_pc       = $urandom;
         fs_payload  = {$urandom, $urandom};
         for (int i = 0; i < NS; i++) fs_src_addr[i*RW +: RW] = 5'($urandom_range(0, 3));
         fs_src_used = 2'($urandom);
         flush       = ($urandom_range(0, 15) == 0);
         stat_clr    = ($urandom_range(0, 40) == 0);
         es_allowin  = ($urandom_range(0, 3) != 0);
         rf_rdata    = {$urandom, $urandom};
         fwd_valid   = 3'($urandom);
         fwd_we      = 3'($urandom);
         for (int k = 0; k < NF; k++) begin
            fwd_ready[k]             = ($urandom_range(0, 3) != 0);
            fwd_dest[k*RW +: RW]     = 5'($urandom_range(0, 3));
            fwd_data[k*XLEN +: XLEN] = $urandom;
         end
         settle();
         checks += 8;
         if (ds_valid !== m_valid) begin errors++; $display("FAIL rnd_valid @%0d got %0h want %0h", n, ds_valid, m_valid); end
         if (ds_pc !== m_pc) begin errors++; $display("FAIL rnd_pc @%0d got %0h want %0h", n, ds_pc, m_pc); end
         if (ds_payload !== m_payload) begin errors++; $display("FAIL rnd_payload @%0d got %0h want %0h", n, ds_payload, m_payload); end
         if (rf_raddr !== m_addr) begin errors++; $display("FAIL rnd_raddr @%0d got %0h want %0h", n, rf_raddr, m_addr); end
         if (ds_stall !== exp_stall) begin errors++; $display("FAIL rnd_stall @%0d got %0h want %0h", n, ds_stall, exp_stall); end
         if (ds_allowin !== exp_allowin) begin errors++; $display("FAIL rnd_allowin @%0d got %0h want %0h", n, ds_allowin, exp_allowin); end
         if (ds2es_valid !== exp_out) begin errors++; $display("FAIL rnd_out @%0d got %0h want %0h", n, ds2es_valid, exp_out); end
         if (int'(stall_cycles) != m_cnt) begin errors++; $display("FAIL rnd_cnt @%0d got %0d want %0d", n, stall_cycles, m_cnt); end
         for (int i = 0; i < NS; i++) begin
            if (!exp_hz[i]) begin
               checks++;
               if (ds_src_data[i*XLEN +: XLEN] !== exp_data[i*XLEN +: XLEN]) begin
                  errors++;
                  $display("FAIL rnd_data%0d @%0d got %0h want %0h", i, n,
                           ds_src_data[i*XLEN +: XLEN], exp_data[i*XLEN +: XLEN]);
               end
            end
         end
         tick();
      end
   endtask

   initial begin
      resetn = 0;
      idle_inputs();
      #1;
      test_reset();
      test_rf_read();
      test_priority();
      test_interlock();
      test_zero_unused();
      test_flush_stall();
      test_saturate();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
